mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single unified memory port between the MIPS instruction-fetch path and the load/store (data) path. Each requester uses a hold-until-acknowledge handshake; the memory side is a request/ready handshake with arbitrary wait states. The block sits between the core's IF/MEM stages and the unified instruction/data memory, and drives a `stall` signal that the pipeline uses to freeze on contention or memory latency.

## Interface
- `ADDR_W`, 32: address width in bits.
- `DATA_W`, 32: data width in bits.
- `STARVE_LIMIT`, 4: maximum consecutive data grants made while `if_req` is pending (range 1..15). Used only when the starvation guard is compiled in.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-low reset.
- `if_req` in 1: instruction-fetch request; held until `if_ack`.
- `if_addr` in ADDR_W: fetch byte address.
- `if_rdata` out DATA_W: fetched word; valid while `if_ack` = 1.
- `if_ack` out 1: one-cycle completion pulse for the fetch requester.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data; valid while `d_ack` = 1.
- `d_ack` out 1: one-cycle completion pulse for the data requester.
- `mem_req` out 1: memory request; held until `mem_ready`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: word-aligned address; bits [1:0] are always 0.
- `mem_wdata` out DATA_W: write data.
- `mem_rdata` in DATA_W: read data; sampled in the `mem_ready` cycle.
- `mem_ready` in 1: memory completion; ignored unless `mem_req` = 1.
- `stall` out 1: combinational; equals (`if_req` & ~`if_ack`) | (`d_req` & ~`d_ack`).

## Operation
The controller is a three-state FSM: IDLE, BUSY, RESP.

- **IDLE**
  - With no request: stay in IDLE.
  - With a request: choose a winner, register its address (with bits [1:0] cleared), `we` and `wdata`, record the owner, and go to BUSY.
  - Stores are issued only by the data port. The fetch port always produces `mem_we` = 0.
- **Priority**
  - Data wins over fetch when both request, because the load/store is the older instruction.
  - Exception: with the starvation guard compiled in, fetch wins when the starvation counter equals `STARVE_LIMIT`.
- **BUSY**
  - `mem_req` = 1, with address, `we` and `wdata` driven from the registered copies. These are stable for the whole state.
  - On `mem_ready` = 1: capture `mem_rdata` into the response register and go to RESP.
  - Zero or more wait cycles are allowed.
- **RESP**
  - Pulse the owner's ack for one cycle.
  - The owner's `rdata` output shows the response register. The other port's `rdata` output holds its last value.
  - Go to IDLE. Requests are not sampled in RESP.
- **Requester rules**
  - Request inputs must stay stable from assertion until ack.
  - `req` still high in the cycle after ack counts as a new request.
  - Store responses also ack; in that case `d_rdata` is don't-care.
- **Reset**
  - `rst` = 0 at any clock edge forces IDLE. Any in-flight transaction is discarded and no ack is issued for it.
  - Reset values: `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `if_ack` = 0, `d_ack` = 0, `if_rdata` = 0, `d_rdata` = 0, starvation counter = 0.
- **`mem_ready` outside BUSY:** ignored.

## Timing
- A request is seen in IDLE at cycle 0. `mem_req` rises at cycle 1.
- If `mem_ready` arrives at cycle k (k ≥ 1), the ack occurs at cycle k+1.
- Minimum latency is 2 cycles (request seen → ack). The arbiter is back in IDLE at k+2.
- Back-to-back throughput with zero-wait memory: one transaction per 3 cycles.
- When both ports request in the same cycle, the loser's `stall` stays high through the winner's whole transaction. The loser is granted at the winner's k+2 IDLE cycle, provided it is still requesting.

## Configuration
- **`MEM_ARB_STARVE_GUARD_EN` defined:** a 4-bit starvation counter is active.
  - It increments on each data grant made while `if_req` = 1.
  - It clears on a fetch grant, and on a data grant made while `if_req` = 0.
  - When it equals `STARVE_LIMIT` and both ports request, fetch is granted.
- **Undefined:** strict data priority. The counter and the `STARVE_LIMIT` comparison are not built, and fetch can starve indefinitely.

## Structure
- **Package `mem_arb_pkg`:** FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2), owner encoding (OWN_IF = 1'b0, OWN_D = 1'b1), and the width of the starvation counter.
- **Sub-module `mem_arb_starve_ctr`:** the counter and its limit compare. It is instantiated only under `MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- **Fetch, zero wait:** `if_req`=1, `if_addr`=0x0000_0043; `mem_ready` asserted the first cycle `mem_req` is high, with `mem_rdata`=0x2008_0005 → `mem_addr`=0x0000_0040, `mem_we`=0, `if_ack` pulse at cycle 2 with `if_rdata`=0x2008_0005, `d_ack` stays 0.
- **Store, 3 wait cycles:** `d_req`=1, `d_we`=1, `d_addr`=0x10, `d_wdata`=0xDEAD_BEEF; `mem_ready` at cycle 4 → `mem_req` high on cycles 1–4 with stable address, `we` and `wdata`; `d_ack` at cycle 5; `stall`=1 on cycles 0–4.
- **Contention:** `if_req` and `d_req` rise together → data is served first; `if_ack` follows after the data transaction's RESP → IDLE.
- **Starvation (guard on, `STARVE_LIMIT`=4):** `d_req` held continuously and `if_req` held continuously → 4 data acks, then 1 fetch ack, then data again. With the macro undefined, no fetch ack is ever issued.
- **Reset mid-operation:** `rst`=0 while in BUSY with `mem_ready` never asserted → next cycle `mem_req`=0, no ack, FSM in IDLE; a new request after reset completes normally.
- **Spurious ready:** `mem_ready`=1 while in IDLE → no state change and no ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - counts data grants made while fetch waits
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant,
    input  logic grant_d,
    input  logic if_req,
    output logic at_limit
);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Count data grants that bypass a waiting fetch; any other grant restarts the run.
    // The count cannot pass the limit: at the limit a waiting fetch wins and clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (grant) begin
            if (grant_d && if_req) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == STARVE_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one memory port (MEM_ARB_STARVE_GUARD_EN adds fetch anti-starvation)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_e        state_q,     state_d;
    arb_owner_e        owner_q,     owner_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

    logic grant;
    logic pick_d;
    logic fetch_turn;

    // Data is the older instruction and normally wins; fetch_turn forces a fetch grant.
    assign grant  = (state_q == ST_IDLE) && (if_req || d_req);
    assign pick_d = d_req && !(if_req && fetch_turn);

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .grant    (grant),
        .grant_d  (pick_d),
        .if_req   (if_req),
        .at_limit (fetch_turn)
    );
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT == 0);
    assign fetch_turn          = 1'b0;
`endif

    // Next-state and output logic: latch the winner in IDLE, hold the memory request
    // until ready, and raise the owner's ack for the single RESP cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d   = ST_BUSY;
                    mem_req_d = 1'b1;
                    if (pick_d) begin
                        owner_d     = OWN_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr & WORD_MASK;
                        mem_wdata_d = d_wdata;
                    end else begin
                        owner_d    = OWN_IF;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr & WORD_MASK;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Arbiter state and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall     = (if_req && !if_ack_q) || (d_req && !d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int LIMIT      = 4;
    localparam int RUN_CYCLES = 4000;
    localparam int TOTAL      = RUN_CYCLES + 300;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stall;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;

    req_t        if_q[$];
    req_t        d_q[$];
    logic [31:0] mem_arr [int unsigned];
    logic [31:0] shadow  [int unsigned];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input int unsigned w);
        return mem_arr.exists(w) ? mem_arr[w] : init_word(w);
    endfunction

    function automatic logic [31:0] shadow_rd(input int unsigned w);
        return shadow.exists(w) ? shadow[w] : init_word(w);
    endfunction

    // Stimulus: reset schedule, both requesters and the memory, driven 1ns after each edge.
    bit          if_out = 1'b0;
    bit          d_out  = 1'b0;
    bit          rst_arm = 1'b0;
    bit          in_reset;
    bit          issue_en;
    int          if_pct;
    int          d_pct;
    int unsigned widx;
    req_t        r;

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        for (int cyc = 0; cyc < TOTAL; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 400 || cyc == 1200 || cyc == 2800) rst_arm = 1'b1;
            in_reset = (cyc < 3) || (rst_arm && mem_req);
            if (in_reset && cyc >= 3) rst_arm = 1'b0;
            rst      = ~in_reset;
            issue_en = (cyc < RUN_CYCLES);
            if (cyc < 1500)      begin if_pct = 40;  d_pct = 50;  end
            else if (cyc < 2500) begin if_pct = 100; d_pct = 100; end
            else                 begin if_pct = 30;  d_pct = 30;  end

            if (in_reset) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end else if (mem_req) begin
                widx      = {2'b00, mem_addr[31:2]};
                mem_ready = ($urandom_range(0, 2) == 0);
                mem_rdata = mem_rd(widx);
                if (mem_ready && mem_we) mem_arr[widx] = mem_wdata;
            end else begin
                mem_ready = ($urandom_range(0, 5) == 0);
                mem_rdata = $urandom;
            end

            if (in_reset) begin
                if_req = 1'b0; d_req = 1'b0; if_out = 1'b0; d_out = 1'b0;
                if_q.delete(); d_q.delete();
            end else begin
                if (if_out) begin
                    if (if_ack) if_out = 1'b0;
                end else if (issue_en && $urandom_range(0, 99) < if_pct) begin
                    r.addr  = $urandom_range(0, 255);
                    r.we    = 1'b0;
                    r.wdata = '0;
                    r.rdata = mem_rd(r.addr >> 2);
                    if_addr = r.addr; if_req = 1'b1; if_out = 1'b1;
                    if_q.push_back(r);
                end else begin
                    if_req = 1'b0;
                end
                if (d_out) begin
                    if (d_ack) d_out = 1'b0;
                end else if (issue_en && $urandom_range(0, 99) < d_pct) begin
                    r.addr  = 32'h100 + $urandom_range(0, 63);
                    r.we    = $urandom_range(0, 1);
                    r.wdata = $urandom;
                    r.rdata = shadow_rd(r.addr >> 2);
                    d_addr = r.addr; d_we = r.we; d_wdata = r.wdata;
                    d_req = 1'b1; d_out = 1'b1;
                    d_q.push_back(r);
                end else begin
                    d_req = 1'b0;
                end
            end
        end
        chk("drain_if_outstanding", {31'd0, if_out}, 32'd0);
        chk("drain_d_outstanding", {31'd0, d_out}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: transaction-level model of who should own the port and when acks appear.
    int          ph = 0;        // 0 = port free, 1 = memory access in flight, 2 = response cycle
    bit          win_d = 1'b0;
    int          starve = 0;
    bit          prev_rst_low = 1'b0;
    logic [31:0] last_if = '0;
    logic [31:0] last_d = '0;
    req_t        cur;

    initial begin
        forever begin
            @(negedge clk);
            chk("stall", {31'd0, stall}, {31'd0, (if_req & ~if_ack) | (d_req & ~d_ack)});
            if (prev_rst_low) begin
                chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
                chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
                chk("rst_mem_addr", mem_addr, 32'd0);
                chk("rst_mem_wdata", mem_wdata, 32'd0);
                chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
                chk("rst_if_rdata", if_rdata, 32'd0);
                chk("rst_d_rdata", d_rdata, 32'd0);
                last_if = '0;
                last_d  = '0;
            end
            prev_rst_low = !rst;
            if (!rst) begin
                ph = 0;
                starve = 0;
            end else begin
                if (if_ack) begin
                    chk("if_ack_has_request", {31'd0, if_q.size() > 0}, 32'd1);
                    if (if_q.size() > 0) begin
                        cur = if_q.pop_front();
                        chk("if_rdata", if_rdata, cur.rdata);
                        last_if = if_rdata;
                    end
                end
                if (d_ack) begin
                    chk("d_ack_has_request", {31'd0, d_q.size() > 0}, 32'd1);
                    if (d_q.size() > 0) begin
                        cur = d_q.pop_front();
                        if (cur.we) shadow[cur.addr >> 2] = cur.wdata;
                        else        chk("d_rdata", d_rdata, cur.rdata);
                        last_d = d_rdata;
                    end
                end
                case (ph)
                    0: begin
                        chk("free_mem_req", {31'd0, mem_req}, 32'd0);
                        chk("free_acks", {30'd0, if_ack, d_ack}, 32'd0);
                        if (if_req || d_req) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
                            win_d = d_req && !(if_req && starve == LIMIT);
                            if (win_d && if_req) starve = starve + 1;
                            else                 starve = 0;
`else
                            win_d = d_req;
`endif
                            ph = 1;
                        end
                    end
                    1: begin
                        chk("busy_owner_queued", {31'd0, (win_d ? d_q.size() : if_q.size()) > 0}, 32'd1);
                        chk("busy_mem_req", {31'd0, mem_req}, 32'd1);
                        chk("busy_acks", {30'd0, if_ack, d_ack}, 32'd0);
                        if ((win_d ? d_q.size() : if_q.size()) > 0) begin
                            cur = win_d ? d_q[0] : if_q[0];
                            chk("mem_addr", mem_addr, cur.addr & 32'hFFFF_FFFC);
                            chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                        end
                        if (mem_ready) ph = 2;
                    end
                    default: begin
                        chk("ack_owner", {30'd0, if_ack, d_ack}, win_d ? 32'd1 : 32'd2);
                        if (win_d) chk("if_rdata_hold", if_rdata, last_if);
                        else       chk("d_rdata_hold", d_rdata, last_d);
                        ph = 0;
                    end
                endcase
            end
        end
    end

endmodule
